// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and helpers for the pipeline hazard controller:
//               controller states, the bundled stall/flush controls and the
//               load-use detection function.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_BUSY  = 2'd1,
        REDIRECT = 2'd2
    } hazard_state_t;

    // Stall/flush pairs for every pipeline register the controller drives
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
    } pipe_ctrl_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // A valid load in EX whose destination is read by the ID instruction
    function automatic logic load_use_hit(
        input logic       ex_valid,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd_addr,
        input logic [4:0] id_rs1_addr,
        input logic [4:0] id_rs2_addr,
        input logic       id_uses_rs1,
        input logic       id_uses_rs2
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
        rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
        return ex_valid && ex_mem_read && (ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_counters
// Description : Free-running 32-bit wrapping counters of pc stall cycles and
//               ID/EX flush cycles. Cleared asynchronously by reset_n.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_stall,
    input  logic        id_ex_flush,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_d;
    logic [31:0] flush_cnt_q;

    // Next-count: bump each counter on a cycle where its event is asserted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (id_ex_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers; reset holds them at zero, so reset-time flushes are not counted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Central pipeline hazard controller. Produces stall/flush
//               controls for pc, IF/ID, ID/EX and EX/MEM from load-use
//               hazards, EX redirects, multi-cycle EX ops and data-memory
//               wait states. Outputs are combinational from registered state
//               and current inputs.
//               Optional macro HAZARD_PERF_EN adds stall/flush perf counters;
//               without it the perf ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MC_TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_redirect,
    input  logic        ex_mc_start,
    input  logic        mc_done,
    input  logic        mem_wait,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mc_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    // One shared counter serves both the multi-cycle timeout and the redirect
    // bubble count; it is sized for whichever needs the larger range.
    localparam int CNT_MAX = (MC_TIMEOUT > REDIRECT_BUBBLES) ? MC_TIMEOUT : REDIRECT_BUBBLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MC_LIMIT = CNT_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] RB_LOAD  = CNT_W'(REDIRECT_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    hazard_state_t    state_d;
    hazard_state_t    state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    pipe_ctrl_t       ctrl;
    logic             timeout_pulse;
    logic             lu_hit;

    assign lu_hit = load_use_hit(ex_valid, ex_mem_read, ex_rd_addr,
                                 id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2);

    // Prioritised hazard resolution: next state/counter and this cycle's controls
    always_comb begin
        ctrl          = '0;
        timeout_pulse = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (mem_wait) begin
            // Whole pipe holds; only a completing multi-cycle op may change state
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            if ((state_q == MC_BUSY) && mc_done) begin
                state_d = RUN;
                cnt_d   = CNT_ZERO;
            end
        end else if (state_q == MC_BUSY) begin
            if (mc_done) begin
                // Result ready: everything advances this cycle
                state_d = RUN;
                cnt_d   = CNT_ZERO;
            end else if (cnt_q >= MC_LIMIT) begin
                // Abort: squash the op in EX while still holding the front end
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
                timeout_pulse     = 1'b1;
                state_d           = RUN;
                cnt_d             = CNT_ZERO;
            end else begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
                cnt_d             = cnt_q + CNT_ONE;
            end
        end else if (ex_redirect) begin
            // pc takes the target; the two younger instructions are wrong-path
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
                state_d = REDIRECT;
                cnt_d   = RB_LOAD;
            end else begin
                state_d = RUN;
                cnt_d   = CNT_ZERO;
            end
        end else if (state_q == REDIRECT) begin
            // Keep bubbling IF/ID while fetch latency drains; load-use ignored
            ctrl.if_id_flush = 1'b1;
            if (cnt_q <= CNT_ONE) begin
                state_d = RUN;
                cnt_d   = CNT_ZERO;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (ex_mc_start && !mc_done) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            state_d           = MC_BUSY;
            cnt_d             = CNT_ONE;
        end else if (lu_hit) begin
            // One bubble into EX; the load then leaves EX and the hazard clears
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end

        if (!reset_n) begin
            ctrl             = '0;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            timeout_pulse    = 1'b0;
        end
    end

    // State and counter registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mc_timeout   = timeout_pulse;

`ifdef HAZARD_PERF_EN
    hazard_perf_counters u_perf (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_stall       (ctrl.pc_stall),
        .id_ex_flush    (ctrl.id_ex_flush),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (REDIRECT_BUBBLES=2,
//               MC_TIMEOUT=6). Table of per-cycle vectors with hand-derived
//               expected outputs, plus a hand-written asynchronous reset
//               sequence and perf-counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Output bit order: {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, timeout}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_RD   = 8'b0010_1000;
    localparam logic [7:0] O_RDB  = 8'b0010_0000;
    localparam logic [7:0] O_MC   = 8'b1101_0010;
    localparam logic [7:0] O_TO   = 8'b1100_1011;
    localparam logic [7:0] O_MW   = 8'b1101_0100;
    localparam logic [7:0] O_RST  = 8'b0010_1000;

    typedef struct packed {
        logic [63:0] tag;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ev;
        logic        mr;
        logic [4:0]  rd;
        logic        redir;
        logic        mcs;
        logic        mcd;
        logic        mw;
        logic [7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
    logic        ex_redirect, ex_mc_start, mc_done, mem_wait;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mc_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [7:0]  dut_out;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [7:0]  exp_q[$];
    logic [63:0] tag_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_BUBBLES(2), .MC_TIMEOUT(6)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd_addr     (ex_rd_addr),
        .ex_redirect    (ex_redirect),
        .ex_mc_start    (ex_mc_start),
        .mc_done        (mc_done),
        .mem_wait       (mem_wait),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_stall    (id_ex_stall),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_stall   (ex_mem_stall),
        .ex_mem_flush   (ex_mem_flush),
        .mc_timeout     (mc_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    assign dut_out = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_stall, ex_mem_flush, mc_timeout};

    function automatic vec_t mk(input logic [63:0] tag,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic ev, input logic mr, input logic [4:0] rd,
                                input logic redir, input logic mcs, input logic mcd,
                                input logic mw, input logic [7:0] exp);
        vec_t v;
        v.tag = tag; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.ev = ev; v.mr = mr; v.rd = rd; v.redir = redir; v.mcs = mcs;
        v.mcd = mcd; v.mw = mw; v.exp = exp;
        return v;
    endfunction

    // Pop one expected value and compare against the live DUT outputs
    task automatic check_out();
        logic [7:0]  e;
        logic [63:0] t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        if (dut_out !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", t, dut_out, e);
        end
    endtask

    task automatic check32(input logic [63:0] tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Drive one vector for exactly one clock, sample mid-cycle
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
        id_uses_rs1 = v.u1;  id_uses_rs2 = v.u2;
        ex_valid    = v.ev;  ex_mem_read = v.mr;  ex_rd_addr = v.rd;
        ex_redirect = v.redir; ex_mc_start = v.mcs;
        mc_done     = v.mcd; mem_wait    = v.mw;
        exp_q.push_back(v.exp);
        tag_q.push_back(v.tag);
        if (v.exp[7]) exp_stall++;
        if (v.exp[3]) exp_flush++;
        @(negedge clk);
        check_out();
    endtask

    initial begin
        reset_n = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
        ex_redirect = 0; ex_mc_start = 0; mc_done = 0; mem_wait = 0;

        //                tag          rs1 rs2 u1 u2 ev mr rd rdr mcs mcd mw exp
        tbl.push_back(mk("idle",       0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("lu_rs1",     5,  0,  1, 0, 1, 1, 5, 0,  0,  0,  0, O_LU));
        tbl.push_back(mk("lu_clear",   5,  0,  1, 0, 0, 1, 5, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("lu_x0",      0,  0,  1, 0, 1, 1, 0, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("lu_rs2",     3,  7,  1, 1, 1, 1, 7, 0,  0,  0,  0, O_LU));
        tbl.push_back(mk("lu_nouse",   3,  7,  1, 0, 1, 1, 7, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("lu_noload",  7,  7,  1, 1, 1, 0, 7, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("redir_c0",   5,  0,  1, 0, 1, 1, 5, 1,  0,  0,  0, O_RD));
        tbl.push_back(mk("redir_c1",   5,  0,  1, 0, 1, 1, 5, 0,  0,  0,  0, O_RDB));
        tbl.push_back(mk("redir_run",  5,  0,  1, 0, 1, 1, 5, 0,  0,  0,  0, O_LU));
        tbl.push_back(mk("mc_c0",      0,  0,  0, 0, 0, 0, 0, 0,  1,  0,  0, O_MC));
        tbl.push_back(mk("mc_c1",      0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_MC));
        tbl.push_back(mk("mc_c2redir", 0,  0,  0, 0, 0, 0, 0, 1,  0,  0,  0, O_MC));
        tbl.push_back(mk("mc_c3",      0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_MC));
        tbl.push_back(mk("mc_c4",      0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_MC));
        tbl.push_back(mk("mc_c5done",  0,  0,  0, 0, 0, 0, 0, 0,  0,  1,  0, O_NONE));
        tbl.push_back(mk("mc_run",     2,  0,  1, 0, 1, 1, 2, 0,  0,  0,  0, O_LU));
        tbl.push_back(mk("mc_same",    0,  0,  0, 0, 0, 0, 0, 0,  1,  1,  0, O_NONE));
        tbl.push_back(mk("mc_same_nx", 0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("to_c0",      0,  0,  0, 0, 0, 0, 0, 0,  1,  0,  0, O_MC));
        for (int i = 1; i < 6; i++)
            tbl.push_back(mk("to_busy",0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_MC));
        tbl.push_back(mk("to_c6",      0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_TO));
        tbl.push_back(mk("to_after",   0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("mw_redir",   0,  0,  0, 0, 0, 0, 0, 1,  0,  0,  0, O_RD));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("mw_hold",0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  1, O_MW));
        tbl.push_back(mk("mw_resume",  0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_RDB));
        tbl.push_back(mk("mw_run",     0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_NONE));
        tbl.push_back(mk("mw_lu",      5,  0,  1, 0, 1, 1, 5, 0,  0,  0,  1, O_MW));
        tbl.push_back(mk("mwmc_c0",    0,  0,  0, 0, 0, 0, 0, 0,  1,  0,  0, O_MC));
        tbl.push_back(mk("mwmc_wait",  0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  1, O_MW));
        tbl.push_back(mk("mwmc_done",  0,  0,  0, 0, 0, 0, 0, 0,  0,  1,  1, O_MW));
        tbl.push_back(mk("mwmc_run",   0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  0, O_NONE));

        // Reset state
        #3;
        exp_q.push_back(O_RST); tag_q.push_back("rst_out");
        check_out();
        check32("rst_pstl", perf_stall_cnt, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Let the last table cycle land in the perf counters
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check32("perf_stl", perf_stall_cnt, exp_stall);
        check32("perf_fls", perf_flush_cnt, exp_flush);
`else
        check32("perf_stl0", perf_stall_cnt, 32'd0);
        check32("perf_fls0", perf_flush_cnt, 32'd0);
`endif

        // Asynchronous reset in the middle of MC_BUSY
        apply(mk("ar_mc0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MC));
        apply(mk("ar_mc1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MC));
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.push_back(O_RST); tag_q.push_back("ar_async");
        #1;
        check_out();
        check32("ar_pstl", perf_stall_cnt, 32'd0);
        check32("ar_pfls", perf_flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(O_RST); tag_q.push_back("ar_held");
        check_out();
        @(negedge clk);
        reset_n = 1'b1;
        apply(mk("ar_run0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        apply(mk("ar_run1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
